// File: rtl/iram_loader.sv
`default_nettype none
// ============================================================================
// iram_loader : UART command host for instruction-RAM LOAD / READ / START.
// Optional: `define IRAM_LOADER_CKSUM_EN adds a trailing LOAD checksum byte.
// Revision    : 1.0
// ============================================================================
module iram_loader #(
  parameter int IRAM_AW = 12,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [IRAM_AW-1:0] i_ram_wadr,
  output logic [31:0]        i_ram_wdata,
  output logic               i_ram_wen,
  output logic [IRAM_AW-1:0] i_ram_radr,
  input  logic [31:0]        i_ram_rdata,
  output logic               i_read_sel,
  output logic               cpu_start,
  output logic [29:0]        start_adr,
  output logic               busy,
  output logic               cksum_err
);

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_START = 8'h03;
  localparam logic [1:0] LEN_LAST = 2'(LEN_W / 8 - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ADDR  = 4'd1,
    S_LEN   = 4'd2,
    S_WDATA = 4'd3,
`ifdef IRAM_LOADER_CKSUM_EN
    S_CKSUM = 4'd4,
`endif
    S_RREQ  = 4'd5,
    S_RWAIT = 4'd6,
    S_RSEND = 4'd7,
    S_GO    = 4'd8
  } state_t;

`ifdef IRAM_LOADER_CKSUM_EN
  localparam state_t LOAD_END = S_CKSUM;
`else
  localparam state_t LOAD_END = S_IDLE;
`endif

  state_t             state;
  state_t             next;
  logic [7:0]         op;
  logic [1:0]         cnt;
  logic [31:0]        addr_sh;
  logic [LEN_W-1:0]   len;
  logic [31:0]        word;
  logic [31:0]        tx_sh;
  logic [IRAM_AW-1:0] ptr;

  logic [31:0]        addr_nx;
  logic [LEN_W-1:0]   len_nx;
  logic [31:0]        word_nx;
  logic               rx_is_cmd;
  logic               unused_bits;

  // Multi-byte fields arrive LSB first, so each byte enters at the top.
  assign addr_nx   = {rx_data, addr_sh[31:8]};
  assign len_nx    = {rx_data, len[LEN_W-1:8]};
  assign word_nx   = {rx_data, word[31:8]};
  assign rx_is_cmd = (rx_data == OP_LOAD) || (rx_data == OP_READ) || (rx_data == OP_START);

  // Byte-address bits [1:0] never select a word.
  assign unused_bits = ^{addr_sh[1:0], addr_nx[1:0]};

  assign tx_data    = tx_sh[7:0];
  assign i_ram_radr = ptr;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next       = state;
    tx_valid   = 1'b0;
    i_read_sel = 1'b0;
    cpu_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid && rx_is_cmd) next = S_ADDR;
      end
      S_ADDR: begin
        if (rx_valid && cnt == 2'd3) next = (op == OP_START) ? S_GO : S_LEN;
      end
      S_LEN: begin
        if (rx_valid && cnt == LEN_LAST) begin
          if (op == OP_LOAD) next = (len_nx == '0) ? LOAD_END : S_WDATA;
          else               next = (len_nx == '0) ? S_IDLE : S_RREQ;
        end
      end
      S_WDATA: begin
        if (rx_valid && cnt == 2'd3 && len == LEN_W'(1)) next = LOAD_END;
      end
`ifdef IRAM_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (rx_valid) next = S_IDLE;
      end
`endif
      S_RREQ: begin
        i_read_sel = 1'b1;
        next       = S_RWAIT;
      end
      S_RWAIT: begin
        i_read_sel = 1'b1;
        next       = S_RSEND;
      end
      S_RSEND: begin
        i_read_sel = 1'b1;
        tx_valid   = 1'b1;
        if (tx_ready && cnt == 2'd3) next = (len == LEN_W'(1)) ? S_IDLE : S_RREQ;
      end
      S_GO: begin
        cpu_start = 1'b1;
        next      = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op          <= '0;
      cnt         <= '0;
      addr_sh     <= '0;
      len         <= '0;
      word        <= '0;
      tx_sh       <= '0;
      ptr         <= '0;
      i_ram_wen   <= 1'b0;
      i_ram_wadr  <= '0;
      i_ram_wdata <= '0;
      start_adr   <= '0;
    end else begin
      i_ram_wen <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid && rx_is_cmd) begin
            op  <= rx_data;
            cnt <= '0;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_sh <= addr_nx;
            cnt     <= cnt + 2'd1;
            if (cnt == 2'd3 && op == OP_START) start_adr <= addr_nx[31:2];
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            len <= len_nx;
            ptr <= addr_sh[IRAM_AW+1:2];
            cnt <= (cnt == LEN_LAST) ? 2'd0 : cnt + 2'd1;
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            word <= word_nx;
            cnt  <= cnt + 2'd1;
            // Write is issued from the completed word so the next byte is never stalled.
            if (cnt == 2'd3) begin
              i_ram_wen   <= 1'b1;
              i_ram_wdata <= word_nx;
              i_ram_wadr  <= ptr;
              ptr         <= ptr + IRAM_AW'(1);
              len         <= len - LEN_W'(1);
            end
          end
        end
        S_RWAIT: begin
          tx_sh <= i_ram_rdata;
          cnt   <= '0;
        end
        S_RSEND: begin
          if (tx_ready) begin
            tx_sh <= {8'h00, tx_sh[31:8]};
            cnt   <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              ptr <= ptr + IRAM_AW'(1);
              len <= len - LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IRAM_LOADER_CKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cksum_err <= 1'b0;
    end else begin
      if (state == S_IDLE && rx_valid && rx_is_cmd) sum <= '0;
      if (state == S_WDATA && rx_valid) sum <= sum + rx_data;
      if (state == S_CKSUM && rx_valid && rx_data != sum) cksum_err <= 1'b1;
    end
  end
`else
  assign cksum_err = 1'b0;
`endif

endmodule
`default_nettype wire
